// File: rtl/ble_cmd_parser.sv
`timescale 1ns/1ps
// Frames UART bytes (HEADER CMD LEN PAYLOAD CSUM) into validated commands or error pulses.
// Latency: cmd_valid/frame_err one cycle after the deciding byte strobe; no backpressure, bytes are never stalled.
module ble_cmd_parser #(
    parameter logic [7:0] HEADER      = 8'hA5,
    parameter int         MAX_LEN     = 4,
    parameter int         TIMEOUT_CYC = 2000000
) (
    input  logic        sys_clk,
    input  logic        rst,
    input  logic [7:0]  rdata,
    input  logic        rx_sig,
    output logic        cmd_valid,
    output logic [7:0]  cmd_code,
    output logic [2:0]  cmd_len,
    output logic [31:0] cmd_data,
    output logic        frame_err,
    output logic [1:0]  err_code
);

    localparam int TW = $clog2(TIMEOUT_CYC);

    typedef enum logic [2:0] {HUNT, CMD, LEN, PAYLOAD, CSUM} state_t;

    state_t        state_q, state_d;
    logic          s1, s2, s2_q;
    logic          byte_stb;
    logic [7:0]    code_q, code_d;
    logic [2:0]    len_q, len_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    sum_q, sum_d;
    logic [31:0]   buf_q, buf_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          valid_d, err_d;
    logic [7:0]    ocode_d;
    logic [2:0]    olen_d;
    logic [31:0]   odata_d;
    logic [1:0]    ecode_d;

    // rdata is stable while rx_sig is low, so it is consumed directly on the strobe
    assign byte_stb = s2_q & ~s2;

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        len_d   = len_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        buf_d   = buf_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        ocode_d = cmd_code;
        olen_d  = cmd_len;
        odata_d = cmd_data;
        ecode_d = err_code;
        tmo_d   = (byte_stb || state_q == HUNT) ? '0 : tmo_q + 1'b1;

        if (byte_stb) begin
            case (state_q)
                HUNT: begin
                    if (rdata == HEADER) state_d = CMD;
                end
                CMD: begin
                    code_d  = rdata;
                    sum_d   = rdata;
                    buf_d   = '0;
                    idx_d   = '0;
                    state_d = LEN;
                end
                LEN: begin
                    sum_d = sum_q + rdata;
                    len_d = rdata[2:0];
                    if (rdata > 8'(MAX_LEN)) begin
                        err_d   = 1'b1;
                        ecode_d = 2'd1;
                        state_d = HUNT;
                    end else if (rdata == 8'd0) begin
                        state_d = CSUM;
                    end else begin
                        state_d = PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    buf_d[{idx_q[1:0], 3'b000} +: 8] = rdata;
                    sum_d = sum_q + rdata;
                    idx_d = idx_q + 3'd1;
                    if (idx_q == len_q - 3'd1) state_d = CSUM;
                end
                CSUM: begin
                    state_d = HUNT;
                    if (rdata == sum_q) begin
                        valid_d = 1'b1;
                        ocode_d = code_q;
                        olen_d  = len_q;
                        odata_d = buf_q;
                    end else begin
                        err_d   = 1'b1;
                        ecode_d = 2'd2;
                    end
                end
                default: state_d = HUNT;
            endcase
        end else if (state_q != HUNT && tmo_q == TW'(TIMEOUT_CYC - 1)) begin
            err_d   = 1'b1;
            ecode_d = 2'd3;
            state_d = HUNT;
            tmo_d   = '0;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q   <= HUNT;
            s1        <= 1'b0;
            s2        <= 1'b0;
            s2_q      <= 1'b0;
            code_q    <= '0;
            len_q     <= '0;
            idx_q     <= '0;
            sum_q     <= '0;
            buf_q     <= '0;
            tmo_q     <= '0;
            cmd_valid <= 1'b0;
            cmd_code  <= '0;
            cmd_len   <= '0;
            cmd_data  <= '0;
            frame_err <= 1'b0;
            err_code  <= '0;
        end else begin
            state_q   <= state_d;
            s1        <= rx_sig;
            s2        <= s1;
            s2_q      <= s2;
            code_q    <= code_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            sum_q     <= sum_d;
            buf_q     <= buf_d;
            tmo_q     <= tmo_d;
            cmd_valid <= valid_d;
            cmd_code  <= ocode_d;
            cmd_len   <= olen_d;
            cmd_data  <= odata_d;
            frame_err <= err_d;
            err_code  <= ecode_d;
        end
    end

endmodule

// File: tb/tb_ble_cmd_parser.sv
`timescale 1ns/1ps
// Scoreboard bench for ble_cmd_parser: expected events queued per frame, popped on each output pulse.
module tb_ble_cmd_parser;

    logic        sys_clk = 1'b0;
    logic        rst;
    logic [7:0]  rdata;
    logic        rx_sig;
    logic        cmd_valid;
    logic [7:0]  cmd_code;
    logic [2:0]  cmd_len;
    logic [31:0] cmd_data;
    logic        frame_err;
    logic [1:0]  err_code;

    ble_cmd_parser #(.HEADER(8'hA5), .MAX_LEN(4), .TIMEOUT_CYC(100)) dut (
        .sys_clk  (sys_clk),
        .rst      (rst),
        .rdata    (rdata),
        .rx_sig   (rx_sig),
        .cmd_valid(cmd_valid),
        .cmd_code (cmd_code),
        .cmd_len  (cmd_len),
        .cmd_data (cmd_data),
        .frame_err(frame_err),
        .err_code (err_code)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic        is_valid;
        logic [7:0]  code;
        logic [2:0]  len;
        logic [31:0] data;
        logic [1:0]  ecode;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          n_vec = 0;
    int          n_err = 0;
    int          stb_cnt = 0;
    logic [7:0]  m_code;
    logic [2:0]  m_len;
    logic [31:0] m_data;
    logic [1:0]  m_ecode;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic exp_valid(input logic [7:0] code, input logic [2:0] len, input logic [31:0] data);
        exp_t e;
        m_code = code;
        m_len  = len;
        m_data = data;
        e = '{1'b1, m_code, m_len, m_data, m_ecode};
        exp_q.push_back(e);
    endtask

    task automatic exp_err(input logic [1:0] ec);
        exp_t e;
        m_ecode = ec;
        e = '{1'b0, m_code, m_len, m_data, m_ecode};
        exp_q.push_back(e);
    endtask

    // UART-like byte: rdata settles, rx_sig pulses high at a random phase, then stays low
    task automatic send_byte(input logic [7:0] b);
        rdata = b;
        #(int'($urandom_range(3, 17)));
        rx_sig = 1'b1;
        #(int'($urandom_range(15, 60)));
        rx_sig = 1'b0;
        #(int'($urandom_range(40, 90)));
    endtask

    task automatic send_frame(input logic [7:0] fr[$]);
        foreach (fr[i]) send_byte(fr[i]);
        repeat (10) @(negedge sys_clk);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, cmd_valid, 0);
        chk({tag, "_code"}, cmd_code, 0);
        chk({tag, "_len"}, cmd_len, 0);
        chk({tag, "_data"}, cmd_data, 0);
        chk({tag, "_ferr"}, frame_err, 0);
        chk({tag, "_ecode"}, err_code, 0);
    endtask

    always @(negedge sys_clk) begin
        if (!rst && dut.byte_stb) stb_cnt++;
        if (!rst && (cmd_valid || frame_err)) begin
            chk("exclusive", cmd_valid & frame_err, 0);
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", {cmd_valid, frame_err}, 0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("cmd_valid", cmd_valid, mon_e.is_valid);
                chk("frame_err", frame_err, !mon_e.is_valid);
                chk("cmd_code", cmd_code, mon_e.code);
                chk("cmd_len", cmd_len, mon_e.len);
                chk("cmd_data", cmd_data, mon_e.data);
                chk("err_code", err_code, mon_e.ecode);
            end
        end
    end

    initial begin
        logic [7:0] fr[$];
        int stb0;
        m_code = '0; m_len = '0; m_data = '0; m_ecode = '0;
        rst = 1'b1; rx_sig = 1'b0; rdata = 8'h00;
        repeat (4) @(negedge sys_clk);
        chk_zero("reset");
        rst = 1'b0;
        repeat (3) @(negedge sys_clk);

        exp_valid(8'h01, 3'd2, 32'h0000_2211);
        fr = '{8'hA5, 8'h01, 8'h02, 8'h11, 8'h22, 8'h36};
        send_frame(fr);

        exp_err(2'd2);
        fr = '{8'hA5, 8'h01, 8'h02, 8'h11, 8'h22, 8'h00};
        send_frame(fr);

        exp_err(2'd1);
        fr = '{8'h55, 8'hA5, 8'h10, 8'h05};
        send_frame(fr);
        exp_valid(8'h7F, 3'd0, 32'h0);
        fr = '{8'hA5, 8'h7F, 8'h00, 8'h7F};
        send_frame(fr);

        exp_err(2'd3);
        fr = '{8'hA5, 8'h01};
        send_frame(fr);
        repeat (120) @(negedge sys_clk);
        exp_valid(8'h02, 3'd1, 32'h0000_00A5);
        fr = '{8'hA5, 8'h02, 8'h01, 8'hA5, 8'hA8};
        send_frame(fr);

        fr = '{8'hA5, 8'h01, 8'h04, 8'hAA};
        foreach (fr[i]) send_byte(fr[i]);
        @(negedge sys_clk);
        rst = 1'b1;
        m_code = '0; m_len = '0; m_data = '0; m_ecode = '0;
        repeat (3) @(negedge sys_clk);
        chk_zero("midrst");
        rst = 1'b0;
        repeat (3) @(negedge sys_clk);
        exp_valid(8'h03, 3'd1, 32'h0000_000F);
        fr = '{8'hA5, 8'h03, 8'h01, 8'h0F, 8'h13};
        send_frame(fr);

        stb0 = stb_cnt;
        exp_valid(8'h09, 3'd4, 32'h0403_0201);
        fr = '{8'hA5, 8'h09, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h17};
        send_frame(fr);
        chk("stb_count", stb_cnt - stb0, 8);

        repeat (20) @(negedge sys_clk);
        chk("drain", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
